// File: rtl/reset_pulse_gen.sv
// Software/power-on reset sequencer: drives OUT_RST for a programmed length, then
// handshakes with the downstream domain's reset status (ACK_IN) with a bounded wait.
module reset_pulse_gen #(
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned DEFAULT_LEN    = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  input  logic [LEN_WIDTH-1:0] REQ_LEN,
  output logic                 REQ_READY,
  output logic                 OUT_RST,
  input  logic                 ACK_IN,
  output logic                 DONE,
  output logic                 TIMEOUT
);

  localparam int unsigned          TimerW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0]    TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0]    TimerSat  = TimerW'(TIMEOUT_CYCLES);
  localparam logic [LEN_WIDTH-1:0] LenOne    = LEN_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitLow, StRelease} state_e;

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic [TimerW-1:0]      timer_q;
  logic [TimerW-1:0]      timer_inc;
  logic                   ack_seen_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   out_rst_q;
  logic                   req_ready_q;
  logic                   done_q;
  logic                   timeout_q;

  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign OUT_RST   = out_rst_q;
  assign REQ_READY = req_ready_q;
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;

  always_comb begin
    timer_inc = (timer_q == TimerSat) ? timer_q : timer_q + TimerW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ACK_IN};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StAssert;
      cnt_q       <= LEN_WIDTH'(DEFAULT_LEN);
      timer_q     <= '0;
      ack_seen_q  <= 1'b0;
      out_rst_q   <= 1'b1;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= timer_inc;
      case (state_q)
        StIdle: begin
          // READY rises one cycle after entering idle, i.e. after the DONE/TIMEOUT pulse
          req_ready_q <= 1'b1;
          if (REQ_VALID && req_ready_q) begin
            state_q     <= StAssert;
            cnt_q       <= (REQ_LEN == '0) ? LenOne : REQ_LEN;
            ack_seen_q  <= 1'b0;
            timer_q     <= '0;
            out_rst_q   <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end
        StAssert: begin
          ack_seen_q <= ack_seen_q | ack_s;
          if (cnt_q <= LenOne) begin
            timer_q <= '0;
            if (ack_seen_q || ack_s) begin
              state_q   <= StRelease;
              out_rst_q <= 1'b0;
            end else begin
              state_q <= StWaitLow;
            end
          end else begin
            cnt_q <= cnt_q - LenOne;
          end
        end
        StWaitLow: begin
          if (ack_s) begin
            state_q   <= StRelease;
            out_rst_q <= 1'b0;
            timer_q   <= '0;
          end else if (timer_q == TimerLast) begin
            state_q   <= StIdle;
            out_rst_q <= 1'b0;
            timeout_q <= 1'b1;
            timer_q   <= '0;
          end
        end
        StRelease: begin
          if (!ack_s) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            timer_q <= '0;
          end else if (timer_q == TimerLast) begin
            state_q   <= StIdle;
            timeout_q <= 1'b1;
            timer_q   <= '0;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_rst_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Scoreboard bench for reset_pulse_gen: stimulus queues expected OUT_RST pulse lengths and
// DONE/TIMEOUT events (with their delay after OUT_RST falls); a monitor pops and compares.
module tb_reset_pulse_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic [7:0] REQ_LEN;
  logic       REQ_READY;
  logic       OUT_RST;
  logic       ACK_IN;
  logic       DONE;
  logic       TIMEOUT;

  typedef struct {
    int kind;  // 0 pulse length, 1 DONE, 2 TIMEOUT
    int val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   ack_force = 1'b0;
  bit   ack_track = 1'b1;
  logic last_out  = 1'b0;

  reset_pulse_gen #(
    .LEN_WIDTH(8),
    .DEFAULT_LEN(16),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_LEN(REQ_LEN),
    .REQ_READY(REQ_READY),
    .OUT_RST(OUT_RST),
    .ACK_IN(ACK_IN),
    .DONE(DONE),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void report(int kind, int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        failures++;
        $display("FAIL event: got kind=%0d val=%0d required kind=%0d val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endfunction

  task automatic push(int kind, int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d events outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic force_hi();
    ack_force = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_req(int len, bit drop_force);
    int n;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: got REQ_READY=0 required 1");
    end
    REQ_VALID = 1'b1;
    REQ_LEN   = 8'(len);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    if (drop_force) begin
      @(negedge CLK);
      ack_force = 1'b0;
    end
  endtask

  // Downstream model: ACK_IN follows OUT_RST one cycle late, optionally forced high.
  initial begin
    ACK_IN = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      ACK_IN   = ack_force | (ack_track & last_out);
      last_out = OUT_RST;
    end
  end

  // Monitor: measures OUT_RST high runs and DONE/TIMEOUT delay after the fall.
  initial begin
    int run;
    int fall_cyc;
    int cyc;
    bit ready_pend;
    run = 0;
    fall_cyc = 0;
    cyc = 0;
    ready_pend = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      cyc++;
      if (ready_pend) begin
        check("ready_after_end", int'(REQ_READY), 1);
        ready_pend = 1'b0;
      end
      if (RST) begin
        run = 0;
      end else if (OUT_RST) begin
        run++;
      end else if (run > 0) begin
        report(0, run);
        fall_cyc = cyc;
        run = 0;
      end
      if (DONE || TIMEOUT) begin
        check("done_timeout_exclusive", int'(DONE && TIMEOUT), 0);
        check("ready_low_at_end", int'(REQ_READY), 0);
        report(DONE ? 1 : 2, cyc - fall_cyc);
        ready_pend = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises;
    int n;
    logic prev;
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_LEN   = 8'd0;

    // Power-on sequence
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_rst", int'(OUT_RST), 1);
    check("reset_ready", int'(REQ_READY), 0);
    check("reset_done", int'(DONE), 0);
    check("reset_timeout", int'(TIMEOUT), 0);
    repeat (3) @(posedge CLK);
    push(0, 16);
    push(1, 4);
    @(negedge CLK);
    RST = 1'b0;
    wait_drain(100);

    // Normal requests with ACK already high: L=3, L=0 (treated as 1), L=255
    force_hi();
    push(0, 3);
    push(1, 4);
    do_req(3, 1'b1);
    wait_drain(100);

    force_hi();
    push(0, 1);
    push(1, 4);
    do_req(0, 1'b1);
    wait_drain(100);

    force_hi();
    push(0, 255);
    push(1, 4);
    do_req(255, 1'b1);
    wait_drain(400);

    // ACK never rises: 4 ASSERT + 8 WAIT_LOW cycles, then TIMEOUT as OUT_RST falls
    ack_force = 1'b0;
    ack_track = 1'b0;
    push(0, 12);
    push(2, 0);
    do_req(4, 1'b0);
    wait_drain(100);

    // ACK stuck high: TIMEOUT 8 cycles into RELEASE
    force_hi();
    push(0, 2);
    push(2, 8);
    do_req(2, 1'b0);
    wait_drain(100);

    // REQ_VALID held high: second acceptance only after READY returns
    push(0, 2);
    push(2, 8);
    push(0, 2);
    push(2, 8);
    REQ_LEN = 8'd2;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    prev  = OUT_RST;
    rises = 0;
    n     = 0;
    while (rises < 2 && n < 100) begin
      @(negedge CLK);
      if (OUT_RST && !prev) rises++;
      prev = OUT_RST;
      n++;
    end
    REQ_VALID = 1'b0;
    check("held_valid_accepts", rises, 2);
    wait_drain(100);

    // RST during RELEASE: OUT_RST rises asynchronously, no end pulse, power-on rerun
    push(0, 2);
    do_req(2, 1'b0);
    n = 0;
    while (OUT_RST && n < 20) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_async_out_rst", int'(OUT_RST), 1);
    check("rst_async_done", int'(DONE), 0);
    check("rst_async_timeout", int'(TIMEOUT), 0);
    ack_force = 1'b0;
    ack_track = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ready_low", int'(REQ_READY), 0);
    push(0, 16);
    push(1, 4);
    RST = 1'b0;
    wait_drain(100);

    // RST mid-ASSERT: sequence aborts silently and restarts with DEFAULT_LEN
    force_hi();
    do_req(50, 1'b0);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_assert_out_rst", int'(OUT_RST), 1);
    check("mid_assert_ready", int'(REQ_READY), 0);
    ack_force = 1'b0;
    repeat (3) @(negedge CLK);
    push(0, 16);
    push(1, 4);
    RST = 1'b0;
    wait_drain(100);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_pulse_gen.md
RESET_PULSE_GEN -- requirements
Module: reset_pulse_gen

Interface
REQ-001 SHALL provide parameter LEN_WIDTH, default 8, width of the requested pulse length.
REQ-002 SHALL provide parameter DEFAULT_LEN, default 16, pulse length used for the power-on sequence.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2 (legal values >= 2), number of flops in the ACK_IN synchronizer.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent waiting for the acknowledge in each wait phase.
REQ-005 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 REQ_VALID  input  1  software reset request.
REQ-008 REQ_LEN  input  LEN_WIDTH  requested OUT_RST assertion length in cycles; sampled when the request is accepted.
REQ-009 REQ_READY  output  1  high only in IDLE.
REQ-010 OUT_RST  output  1  active-high reset driven to the downstream domain.
REQ-011 ACK_IN  input  1  asynchronous status from the downstream domain; high while that domain is held in reset.
REQ-012 DONE  output  1  one-cycle pulse when a sequence completes normally.
REQ-013 TIMEOUT  output  1  one-cycle pulse when a sequence is aborted by timeout.

Function
REQ-014 ACK_IN SHALL pass through SYNC_STAGES flops before use; ack_s denotes the last stage.
REQ-015 The FSM SHALL have four states: IDLE, ASSERT, WAIT_LOW, RELEASE.
REQ-016 A request SHALL be accepted when REQ_VALID && REQ_READY at posedge CLK; on acceptance the FSM SHALL enter ASSERT, load cnt=max(REQ_LEN,1), clear the ack_seen flag and clear the timer.
REQ-017 While REQ_READY is low, REQ_VALID SHALL be ignored; requests SHALL NOT be queued.
REQ-018 OUT_RST SHALL be registered and SHALL equal 1 in ASSERT and WAIT_LOW, and 0 in IDLE and RELEASE.
REQ-019 In ASSERT, cnt SHALL decrement by 1 per cycle, and ack_seen SHALL set when ack_s==1.
REQ-020 When cnt reaches 1 in ASSERT, the FSM SHALL go to RELEASE if ack_seen (or ack_s this cycle) is set; otherwise it SHALL go to WAIT_LOW.
REQ-021 Consequence of REQ-016/018/020: for an accepted length L with ACK already seen, OUT_RST SHALL be high for exactly L cycles, with the first high cycle immediately after acceptance.
REQ-022 WAIT_LOW SHALL keep OUT_RST high until ack_s==1, then go to RELEASE; after TIMEOUT_CYCLES cycles it SHALL instead pulse TIMEOUT and go to IDLE (OUT_RST falls).
REQ-023 RELEASE SHALL hold OUT_RST low until ack_s==0, then pulse DONE and go to IDLE; after TIMEOUT_CYCLES cycles it SHALL instead pulse TIMEOUT and go to IDLE.
REQ-024 The timer SHALL clear on every state entry and saturate, never wrap; DONE and TIMEOUT SHALL never be high in the same cycle.
REQ-025 Width rules: cnt SHALL be LEN_WIDTH bits; REQ_LEN=0 SHALL be treated as 1; REQ_LEN=2^LEN_WIDTH-1 SHALL be honoured without overflow.
REQ-026 REQ_READY SHALL rise in the cycle after DONE or TIMEOUT.

Reset
REQ-027 While RST=1: state=ASSERT, OUT_RST=1, REQ_READY=0, DONE=0, TIMEOUT=0, synchronizer flops=0, ack_seen=0, cnt=DEFAULT_LEN.
REQ-028 After RST deasserts, the power-on sequence SHALL run as a normal sequence of length DEFAULT_LEN (REQ-019..REQ-023).
REQ-029 RST asserted mid-sequence SHALL immediately drive OUT_RST=1 and abort the sequence without a DONE or TIMEOUT pulse.

Verification
REQ-030 RST high 5 cycles then low, ACK_IN tracks OUT_RST with a 1-cycle lag -> OUT_RST high for 16 cycles after RST falls, DONE pulses once, REQ_READY=1 the next cycle.
REQ-031 In IDLE, REQ_VALID with REQ_LEN=3 and ACK_IN high -> OUT_RST high exactly 3 cycles; DONE follows once ack_s falls.
REQ-032 REQ_LEN=0 -> 1-cycle OUT_RST pulse; REQ_LEN=255 -> 255-cycle pulse.
REQ-033 ACK_IN held 0 with TIMEOUT_CYCLES=8 -> OUT_RST stays high through 8 WAIT_LOW cycles, TIMEOUT pulses, no DONE, IDLE reached.
REQ-034 ACK_IN stuck 1 -> TIMEOUT pulse after 8 RELEASE cycles with OUT_RST=0.
REQ-035 REQ_VALID held high during a sequence -> no second acceptance until REQ_READY=1; RST pulsed mid-ASSERT -> OUT_RST=1 asynchronously and the sequence restarts with length DEFAULT_LEN.
